// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs opcode/register/function fields and an immediate into a 32-bit word,
// with one valid/ready output register and a saturating error counter. Optional RANGE_CHECK_EN flags unrepresentable immediates.
`timescale 1ns/1ps
module instruction_encoder #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           opcode,
   input  logic [4:0]           rd,
   input  logic [4:0]           rs1,
   input  logic [4:0]           rs2,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   input  logic [31:0]          imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          instr,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (&c) ? c : c + ERR_CNT_W'(1);
   endfunction

`ifdef RANGE_CHECK_EN
   // A field is representable when every bit above its sign bit matches the sign bit.
   function automatic logic range_err(input logic [6:0] op, input logic [31:0] v);
      logic e;
      e = 1'b0;
      case (op)
         OP_LOAD, OP_IMM, OP_JALR, OP_STORE: e = !((&v[31:11]) || !(|v[31:11]));
         OP_BRANCH:                          e = !((&v[31:12]) || !(|v[31:12])) || v[0];
         OP_LUI, OP_AUIPC:                   e = |v[11:0];
         OP_JAL:                             e = !((&v[31:19]) || !(|v[31:19]));
         default:                            e = 1'b0;
      endcase
      return e;
   endfunction
`else
   logic unused_imm_lsb;
   assign unused_imm_lsb = imm[0];
`endif

   logic [31:0]          enc_instr;
   logic                 enc_err;
   logic                 accept;
   logic                 out_valid_d, out_valid_q;
   logic [31:0]          instr_d, instr_q;
   logic                 err_d, err_q;
   logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

   always_comb begin
      enc_instr = 32'h0;
      enc_err   = 1'b0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR:
            enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
         OP_STORE:
            enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         OP_BRANCH:
            enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         OP_LUI, OP_AUIPC:
            enc_instr = {imm[31:12], rd, opcode};
         OP_JAL:
            enc_instr = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
         OP_REG:
            enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
         default:
            enc_err = 1'b1;
      endcase
`ifdef RANGE_CHECK_EN
      enc_err = enc_err | range_err(opcode, imm);
`endif
   end

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = accept || (out_valid_q && !out_ready);
      instr_d     = instr_q;
      err_d       = err_q;
      err_cnt_d   = err_cnt_q;
      if (accept) begin
         instr_d = enc_instr;
         err_d   = enc_err;
         if (enc_err) err_cnt_d = sat_inc(err_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         instr_q     <= 32'h0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         instr_q     <= instr_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign instr     = instr_q;
   assign err       = err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized + directed bench for instruction_encoder against a shift/mask reference model and a stream scoreboard.
`timescale 1ns/1ps
module tb_instruction_encoder;
   localparam int ERR_CNT_W = 8;
   localparam int unsigned CNT_MAX = (1 << ERR_CNT_W) - 1;
`ifdef RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif
   localparam logic [6:0] OPS [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

   logic                 clk = 1'b0, rst_n = 1'b0;
   logic                 in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, err;
   logic [6:0]           opcode = 7'h0, funct7 = 7'h0;
   logic [4:0]           rd = 5'h0, rs1 = 5'h0, rs2 = 5'h0;
   logic [2:0]           funct3 = 3'h0;
   logic [31:0]          imm = 32'h0, instr;
   logic [ERR_CNT_W-1:0] err_cnt;

   int total = 0, bad = 0;

   instruction_encoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
      .err(err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: place immediate bits by arithmetic, range by signed value bounds.
   task automatic model_enc(input logic [6:0] op, input logic [4:0] d, s1, s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] im,
                            output logic [31:0] w, output logic e);
      int unsigned u, base;
      int si;
      u = im; si = int'(im);
      base = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
      e = 1'b0;
      case (op)
         7'h03, 7'h13, 7'h67: begin
            w = ((u & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'(op);
            e = RC && (si < -2048 || si > 2047);
         end
         7'h23: begin
            w = (((u >> 5) & 32'h7F) << 25) | base | ((u & 32'h1F) << 7) | 32'(op);
            e = RC && (si < -2048 || si > 2047);
         end
         7'h63: begin
            w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | base |
                (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'(op);
            e = RC && (si < -4096 || si > 4095 || (u % 2) == 1);
         end
         7'h37, 7'h17: begin
            w = (u & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
            e = RC && ((u % 4096) != 0);
         end
         7'h6F: begin
            w = (((u >> 19) & 1) << 31) | ((u & 32'h3FF) << 21) | (((u >> 10) & 1) << 20) |
                (((u >> 11) & 32'hFF) << 12) | (32'(d) << 7) | 32'(op);
            e = RC && (si < -524288 || si > 524287);
         end
         7'h33: w = (32'(f7) << 25) | base | (32'(d) << 7) | 32'(op);
         default: begin w = 32'h0; e = 1'b1; end
      endcase
   endtask

   // Scoreboard: at most one pending word, sampled on the falling edge.
   logic [32:0]  exp_q[$];
   int unsigned  m_cnt = 0;
   logic [31:0]  last_instr = 32'h0;

   always @(negedge clk) begin
      logic [31:0] mi;
      logic        me;
      logic        mrdy;
      if (!rst_n) begin
         exp_q.delete(); m_cnt = 0; last_instr = 32'h0;
         chk("rst_out_valid", 32'(out_valid), 32'h0);
         chk("rst_err_cnt", 32'(err_cnt), 32'h0);
      end else begin
         mrdy = (exp_q.size() == 0) || out_ready;
         chk("in_ready", 32'(in_ready), 32'(mrdy));
         chk("err_cnt", 32'(err_cnt), m_cnt);
         chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         if (out_valid && exp_q.size() != 0) begin
            chk("instr", instr, exp_q[0][31:0]);
            chk("err", 32'(err), 32'(exp_q[0][32]));
         end else if (!out_valid) begin
            chk("instr_hold", instr, last_instr);
         end
         if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         if (in_valid && mrdy) begin
            model_enc(opcode, rd, rs1, rs2, funct3, funct7, imm, mi, me);
            exp_q.push_back({me, mi});
            last_instr = mi;
            if (me && m_cnt < CNT_MAX) m_cnt++;
         end
      end
   end

   task automatic do_reset();
      in_valid = 1'b0; out_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] d, s1, s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
      bit ok;
      ok = 1'b0;
      opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("send_accepted", 32'(ok), 32'h1);
   endtask

   initial begin
      logic [31:0] w;
      logic        e;
      logic [31:0] r;

      // Pin the model with hand-derived encodings.
      model_enc(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, w, e);       chk("model_addi", w, 32'h00500093);
      model_enc(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8, w, e);       chk("model_sw", w, 32'h0021A423);
      model_enc(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, w, e); chk("model_beq", w, 32'hFE208EE3);
      model_enc(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, w, e);    chk("model_addi2048", w, 32'h80000093);
      model_enc(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, w, e); chk("model_lui", w, 32'h123452B7);
      model_enc(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, w, e);       chk("model_jal", w, 32'h008000EF);

      do_reset();
      chk("reset_instr", instr, 32'h0);
      chk("reset_err", 32'(err), 32'h0);

      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      chk("addi_valid", 32'(out_valid), 32'h1);
      chk("addi_instr", instr, 32'h00500093);
      chk("addi_err", 32'(err), 32'h0);

      send(7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 7'd0, 32'd8);
      chk("sw_instr", instr, 32'h0021A423);
      send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
      chk("beq_instr", instr, 32'hFE208EE3);
      chk("beq_valid", 32'(out_valid), 32'h1);

      // Backpressure: first word stalls, second request waits.
      @(posedge clk); #1;
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      out_ready = 1'b0;
      opcode = 7'h13; rd = 5'd2; rs1 = 5'd0; funct3 = 3'd0; imm = 32'd7; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'h0);
         chk("bp_instr", instr, 32'h00500093);
         chk("bp_valid", 32'(out_valid), 32'h1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second", instr, 32'h00700113);
      @(posedge clk); #1;
      chk("drain_valid", 32'(out_valid), 32'h0);
      chk("drain_hold", instr, 32'h00700113);

      do_reset();
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      chk("range_instr", instr, 32'h80000093);
      chk("range_err", 32'(err), 32'(RC));
      chk("range_cnt", 32'(err_cnt), 32'(RC));

      // Randomized traffic.
      do_reset();
      repeat (1500) begin
         r = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         opcode = ($urandom_range(0, 7) == 0) ? 7'($urandom) : OPS[$urandom_range(0, 9)];
         rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
         funct3 = 3'($urandom); funct7 = 7'($urandom);
         case ($urandom_range(0, 4))
            0: imm = r;
            1: imm = {{20{r[11]}}, r[11:0]};
            2: imm = {{19{r[12]}}, r[12:1], 1'b0};
            3: imm = {r[31:12], 12'h0};
            default: imm = {{12{r[19]}}, r[19:0]};
         endcase
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Error counter saturation.
      do_reset();
      opcode = 7'h7F; in_valid = 1'b1; out_ready = 1'b1;
      repeat (300) @(posedge clk);
      #1 in_valid = 1'b0;
      chk("sat_cnt", 32'(err_cnt), 32'd255);
      chk("sat_instr", instr, 32'h0);
      chk("sat_err", 32'(err), 32'h1);

      // Asynchronous reset mid-stall.
      do_reset();
      out_ready = 1'b0;
      send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_cnt", 32'(err_cnt), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'h0);
      chk("async_rst_cnt", 32'(err_cnt), 32'h0);
      chk("async_rst_instr", instr, 32'h0);
      @(posedge clk); #2 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule
